cpu_dma_bus_master: RTL and testbench
=====================================

// Module: cpu_dma_bus_master
// PURPOSE
// - Bus master between the 6502 core and system bus; generalised OAM-DMA engine (NES $4014).
// - A CPU write to TRIGGER_ADDR with page P halts the core via o_rdy.
// - The engine then copies LENGTH bytes from {P, 0...} to DEST_ADDR, alternating read/write cycles.
// - Passes core bus signals through unchanged when idle; owns o_rw/o_address/o_data while transferring.
// PARAMETERS
// - ADDR_WIDTH    16       bus address width
// - DATA_WIDTH     8       bus data width; source page width
// - TRIGGER_ADDR  16'h4014 CPU write address that starts a transfer
// - DEST_ADDR     16'h2004 destination address (first byte)
// - LENGTH        256      bytes per transfer, 1..2**(ADDR_WIDTH-DATA_WIDTH)
// - DEST_INC       0       0: fixed destination (OAM port); 1: destination increments per byte (memcpy mode)
// PORTS
// - i_clk        in   1           clock
// - i_reset_n    in   1           synchronous active-low reset
// - i_cpu_rw     in   1           core read/write, 1 = READ, 0 = WRITE
// - i_cpu_address in  ADDR_WIDTH  core address
// - i_cpu_data   in   DATA_WIDTH  core write data
// - o_rdy        out  1           1 = core runs; 0 = core must hold all state this cycle
// - o_rw         out  1           bus read/write, 1 = READ
// - o_address    out  ADDR_WIDTH  bus address
// - o_data       out  DATA_WIDTH  bus write data
// - i_data       in   DATA_WIDTH  bus read data (also seen by core)
// - o_busy       out  1           high from HALT through the last WRITE
// - o_done       out  1           one-cycle pulse in the cycle after the last WRITE
// BEHAVIOUR
// - Reset: state IDLE, parity=0, index=0, o_rdy=1, o_busy=0, o_done=0; bus outputs mirror core inputs.
// - parity: 1-bit register, toggles every clock from reset; 0 = even (get) cycle, 1 = odd (put) cycle.
// - Trigger: in IDLE, i_cpu_rw=0 AND i_cpu_address==TRIGGER_ADDR. Page register <= i_cpu_data; next state HALT.
//   - The trigger write itself completes on the bus normally.
// - States:
//   - IDLE: pass-through; o_rdy=1.
//   - HALT: 1 cycle; o_rdy=0; o_address=i_cpu_address; o_rw forced 1 (dummy read).
//     Next state is READ if the parity in the next cycle is even, else ALIGN.
//   - ALIGN: 1 cycle; same bus drive as HALT; next state READ.
//   - READ: o_address = ({page, 0} + index), truncated to ADDR_WIDTH; o_rw=1.
//     Byte register <= i_data at clock edge; next state WRITE.
//   - WRITE: o_address = DEST_ADDR + (DEST_INC ? index : 0), mod 2**ADDR_WIDTH; o_rw=0; o_data = byte register.
//     index++; next state READ if index+1 < LENGTH, else IDLE with o_done=1.
// - o_rdy=0 and o_busy=1 in HALT/ALIGN/READ/WRITE.
// - o_rdy returns to 1 in the same cycle o_done pulses.
// - Total stall: 1 + align + 2*LENGTH cycles (513 or 514 for LENGTH=256).
// - Index counter width is clog2(LENGTH+1); it resets to 0 on every trigger.
// - Source address wraps mod 2**ADDR_WIDTH.
// - Trigger qualification while busy: ignored (the core is halted, so a held write to TRIGGER_ADDR cannot retrigger).
// - Back-to-back: a trigger in the o_done cycle (core running) is accepted.
// - Reset mid-transfer: the next cycle is IDLE with o_rdy=1; no further DMA bus writes; the byte register is cleared.
// - Pass-through is combinational (core -> bus, zero latency). DMA drive derives from registered state/index only.
// - o_data in READ/HALT/ALIGN = byte register (don't-care, but held stable).
// STRUCTURE
// - Package cpu_dma_pkg:
//   - state typedef {IDLE, HALT, ALIGN, READ, WRITE}
//   - NES defaults: TRIGGER 16'h4014, DEST 16'h2004, LENGTH 256.
// - Single module. Parity toggle, index counter and output mux stay inline; no sub-module is needed.
// TESTING
// - Pass-through: core reads $C000 then writes $55 to $0200 -> bus mirrors both; o_rdy stays 1.
// - Even start: write $02 to $4014 with next parity even.
//   - Expect o_rdy low for exactly 513 cycles.
//   - Reads at $0200..$02FF; each followed by a write of the same byte to $2004.
//   - o_done pulses once.
// - Odd start: same trigger with next parity odd -> one ALIGN cycle; 514-cycle stall; first READ on an even cycle.
// - DEST_INC=1, LENGTH=4, DEST_ADDR=$0300: page $07 containing 11,22,33,44.
//   - Expect writes to $0300..$0303 with the same data; stall of 9 or 10 cycles.
// - Reset asserted at the 100th READ -> next cycle IDLE, o_rdy=1, o_busy=0; no write to $2004 after reset.
// - Boundary: page $FF, LENGTH=256 -> reads $FF00..$FFFF with no wrap into $0000.
//   - Then a retrigger in the o_done cycle -> a new HALT follows immediately.

Source files
------------

// File: rtl/cpu_dma_pkg.sv
// Shared types and NES defaults for the 6502 bus master / OAM-DMA engine.
// Imported by cpu_dma_bus_master.
package cpu_dma_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    ALIGN,
    READ,
    WRITE
  } state_e;

  localparam logic [15:0] NES_TRIGGER = 16'h4014;
  localparam logic [15:0] NES_DEST    = 16'h2004;
  localparam int          NES_LENGTH  = 256;

endpackage

// File: rtl/cpu_dma_bus_master.sv
// 6502 bus master: passes the core through, or halts it and copies
// LENGTH bytes from a source page to DEST_ADDR (NES $4014 OAM-DMA).
module cpu_dma_bus_master
  import cpu_dma_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = 16,
  parameter int                    DATA_WIDTH   = 8,
  parameter logic [ADDR_WIDTH-1:0] TRIGGER_ADDR = NES_TRIGGER,
  parameter logic [ADDR_WIDTH-1:0] DEST_ADDR    = NES_DEST,
  parameter int                    LENGTH       = NES_LENGTH,
  parameter int                    DEST_INC     = 0
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_cpu_rw,
  input  logic [ADDR_WIDTH-1:0] i_cpu_address,
  input  logic [DATA_WIDTH-1:0] i_cpu_data,
  output logic                  o_rdy,
  output logic                  o_rw,
  output logic [ADDR_WIDTH-1:0] o_address,
  output logic [DATA_WIDTH-1:0] o_data,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int IW = $clog2(LENGTH + 1);
  localparam int SH = ADDR_WIDTH - DATA_WIDTH;
  localparam logic [IW-1:0] LAST_IDX = IW'(LENGTH - 1);

  state_e                state_q, state_d;
  logic                  parity_q;
  logic [IW-1:0]         index_q, index_d;
  logic [DATA_WIDTH-1:0] page_q, page_d;
  logic [DATA_WIDTH-1:0] byte_q, byte_d;
  logic                  done_q, done_d;

  logic                  trig;
  logic [ADDR_WIDTH-1:0] src_addr;
  logic [ADDR_WIDTH-1:0] dst_addr;
  logic [ADDR_WIDTH-1:0] dst_ofs;

  assign trig = !i_cpu_rw
             && (i_cpu_address == TRIGGER_ADDR);

  // Source wraps naturally through the truncating add.
  assign src_addr = {page_q, {SH{1'b0}}}
                  + ADDR_WIDTH'(index_q);

  assign dst_ofs  = (DEST_INC != 0)
                  ? ADDR_WIDTH'(index_q)
                  : '0;
  assign dst_addr = DEST_ADDR + dst_ofs;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q  <= IDLE;
      parity_q <= 1'b0;
      index_q  <= '0;
      page_q   <= '0;
      byte_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      parity_q <= ~parity_q;
      index_q  <= index_d;
      page_q   <= page_d;
      byte_q   <= byte_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    page_d  = page_q;
    byte_d  = byte_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (trig) begin
          page_d  = i_cpu_data;
          index_d = '0;
          state_d = HALT;
        end
      end
      // parity_q=1 now means the next cycle is an even (get) cycle.
      HALT:  state_d = parity_q ? READ : ALIGN;
      ALIGN: state_d = READ;
      READ: begin
        byte_d  = i_data;
        state_d = WRITE;
      end
      WRITE: begin
        index_d = index_q + 1'b1;
        if (index_q == LAST_IDX) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = READ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_rdy     = 1'b1;
    o_busy    = 1'b0;
    o_rw      = i_cpu_rw;
    o_address = i_cpu_address;
    o_data    = i_cpu_data;
    unique case (state_q)
      IDLE: ;
      HALT, ALIGN: begin
        o_rdy  = 1'b0;
        o_busy = 1'b1;
        o_rw   = 1'b1;
        o_data = byte_q;
      end
      READ: begin
        o_rdy     = 1'b0;
        o_busy    = 1'b1;
        o_rw      = 1'b1;
        o_address = src_addr;
        o_data    = byte_q;
      end
      WRITE: begin
        o_rdy     = 1'b0;
        o_busy    = 1'b1;
        o_rw      = 1'b0;
        o_address = dst_addr;
        o_data    = byte_q;
      end
      default: ;
    endcase
  end

  assign o_done = done_q;

endmodule

// File: tb/tb_cpu_dma_bus_master.sv
// Directed bench for cpu_dma_bus_master: NES instance plus a
// small memcpy-mode instance, both reading one shared memory model.
module tb_cpu_dma_bus_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        c1_rw, c2_rw;
  logic [15:0] c1_a, c2_a;
  logic [7:0]  c1_d, c2_d;
  logic        r1_rdy, r1_rw, r1_busy, r1_done;
  logic        r2_rdy, r2_rw, r2_busy, r2_done;
  logic [15:0] r1_a, r2_a;
  logic [7:0]  r1_do, r2_do, r1_di, r2_di;

  logic [7:0]  mem [0:65535];
  assign r1_di = mem[r1_a];
  assign r2_di = mem[r2_a];

  cpu_dma_bus_master dut (
    .i_clk         (clk),
    .i_reset_n     (rst_n),
    .i_cpu_rw      (c1_rw),
    .i_cpu_address (c1_a),
    .i_cpu_data    (c1_d),
    .o_rdy         (r1_rdy),
    .o_rw          (r1_rw),
    .o_address     (r1_a),
    .o_data        (r1_do),
    .i_data        (r1_di),
    .o_busy        (r1_busy),
    .o_done        (r1_done)
  );

  cpu_dma_bus_master #(
    .DEST_ADDR (16'h0300),
    .LENGTH    (4),
    .DEST_INC  (1)
  ) dut2 (
    .i_clk         (clk),
    .i_reset_n     (rst_n),
    .i_cpu_rw      (c2_rw),
    .i_cpu_address (c2_a),
    .i_cpu_data    (c2_d),
    .o_rdy         (r2_rdy),
    .o_rw          (r2_rw),
    .o_address     (r2_a),
    .o_data        (r2_do),
    .i_data        (r2_di),
    .o_busy        (r2_busy),
    .o_done        (r2_done)
  );

  typedef struct {
    logic        rdy;
    logic        rw;
    logic        busy;
    logic        done;
    logic [15:0] a;
    logic [7:0]  d;
    int          c;
  } smp_t;

  smp_t tr[$];
  int   cyc;
  int   checks;
  int   passes;

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle();
    c1_rw = 1'b1; c1_a = 16'hC123; c1_d = 8'h00;
    c2_rw = 1'b1; c2_a = 16'hC123; c2_d = 8'h00;
  endtask

  task automatic drive_trig(input bit sel, input logic [7:0] pg);
    if (sel) begin
      c2_rw = 1'b0; c2_a = 16'h4014; c2_d = pg;
    end else begin
      c1_rw = 1'b0; c1_a = 16'h4014; c1_d = pg;
    end
  endtask

  task automatic do_reset();
    step();
    rst_n = 1'b0;
    idle();
    step();
    rst_n = 1'b1;
    cyc = 0;
    #1;
  endtask

  // Trigger cycle gets parity par; par=0 means an even start.
  task automatic trigger(input bit sel, input logic [7:0] pg,
                         input int par);
    while (((cyc + 1) & 1) != par) begin
      step();
      idle();
    end
    step();
    idle();
    drive_trig(sel, pg);
    #1;
  endtask

  task automatic capture(input bit sel, input int retrig,
                         input logic [7:0] pg, input int maxc);
    smp_t s;
    tr.delete();
    for (int n = 0; n < maxc; n++) begin
      step();
      idle();
      if (n == retrig) drive_trig(sel, pg);
      #1;
      s.rdy  = sel ? r2_rdy  : r1_rdy;
      s.rw   = sel ? r2_rw   : r1_rw;
      s.busy = sel ? r2_busy : r1_busy;
      s.done = sel ? r2_done : r1_done;
      s.a    = sel ? r2_a    : r1_a;
      s.d    = sel ? r2_do   : r1_do;
      s.c    = cyc;
      tr.push_back(s);
      if (retrig < 0 && s.done) break;
      if (retrig >= 0 && n == retrig + 1) break;
    end
  endtask

  function automatic int stall_count();
    int k = 0;
    foreach (tr[i]) if (!tr[i].rdy) k++;
    return k;
  endfunction

  function automatic int done_count();
    int k = 0;
    foreach (tr[i]) if (tr[i].done) k++;
    return k;
  endfunction

  task automatic test_reset();
    c1_rw = 1'b1; c1_a = 16'hABCD; c1_d = 8'h3C;
    #1;
    checks++;
    if ({r1_rdy, r1_busy, r1_done} !== 3'b100)
      $display("FAIL reset_flags got %b want 100",
               {r1_rdy, r1_busy, r1_done});
    else passes++;
    checks++;
    if ({r1_rw, r1_a, r1_do} !== {1'b1, 16'hABCD, 8'h3C})
      $display("FAIL reset_pass got %h want 1abcd3c",
               {r1_rw, r1_a, r1_do});
    else passes++;
    checks++;
    if ({r2_rdy, r2_busy, r2_done} !== 3'b100)
      $display("FAIL reset_flags2 got %b want 100",
               {r2_rdy, r2_busy, r2_done});
    else passes++;
  endtask

  task automatic test_passthrough();
    step();
    idle();
    c1_a = 16'hC000;
    #1;
    checks++;
    if ({r1_rdy, r1_rw, r1_a} !== {2'b11, 16'hC000})
      $display("FAIL pt_read got %h want 3c000",
               {r1_rdy, r1_rw, r1_a});
    else passes++;
    checks++;
    if (r1_di !== mem[16'hC000])
      $display("FAIL pt_rdata got %h want %h", r1_di, mem[16'hC000]);
    else passes++;
    step();
    c1_rw = 1'b0; c1_a = 16'h0200; c1_d = 8'h55;
    #1;
    checks++;
    if ({r1_rdy, r1_rw, r1_a, r1_do} !== {2'b10, 16'h0200, 8'h55})
      $display("FAIL pt_write got %h want 2020055",
               {r1_rdy, r1_rw, r1_a, r1_do});
    else passes++;
    step();
    idle();
    #1;
    checks++;
    if ({r1_rdy, r1_busy} !== 2'b10)
      $display("FAIL pt_no_trig got %b want 10", {r1_rdy, r1_busy});
    else passes++;
  endtask

  task automatic check_xfer(input string nm, input int off,
                            input logic [15:0] base);
    logic [15:0] ea;
    int bad = 0;
    for (int i = 0; i < 256; i++) begin
      ea = base + 16'(i);
      if ({tr[off+2*i].rw, tr[off+2*i].busy, tr[off+2*i].a}
          !== {2'b11, ea}) begin
        bad++;
        $display("FAIL %s_read%0d got %h want %h", nm, i,
                 tr[off+2*i].a, ea);
      end
      if ({tr[off+2*i+1].rw, tr[off+2*i+1].a, tr[off+2*i+1].d}
          !== {1'b0, 16'h2004, mem[ea]}) begin
        bad++;
        $display("FAIL %s_write%0d got %h/%h want 2004/%h", nm, i,
                 tr[off+2*i+1].a, tr[off+2*i+1].d, mem[ea]);
      end
    end
    checks++;
    if (bad !== 0)
      $display("FAIL %s_pairs got %0d bad want 0", nm, bad);
    else passes++;
  endtask

  task automatic test_even_start();
    trigger(0, 8'h02, 0);
    checks++;
    if ({r1_rdy, r1_rw, r1_a, r1_do} !== {2'b10, 16'h4014, 8'h02})
      $display("FAIL even_trigwr got %h want 2401402",
               {r1_rdy, r1_rw, r1_a, r1_do});
    else passes++;
    capture(0, -1, 8'h00, 600);
    checks++;
    if (tr.size() !== 514) begin
      $display("FAIL even_len got %0d want 514", tr.size());
    end else begin
      passes++;
      checks++;
      if (stall_count() !== 513)
        $display("FAIL even_stall got %0d want 513", stall_count());
      else passes++;
      checks++;
      if (done_count() !== 1)
        $display("FAIL even_done got %0d want 1", done_count());
      else passes++;
      checks++;
      if ({tr[0].rw, tr[0].busy, tr[0].a} !== {2'b11, 16'hC123})
        $display("FAIL even_halt got %h want 3c123", tr[0].a);
      else passes++;
      check_xfer("even", 1, 16'h0200);
      checks++;
      if ({tr[513].done, tr[513].rdy, tr[513].busy} !== 3'b110)
        $display("FAIL even_end got %b want 110",
                 {tr[513].done, tr[513].rdy, tr[513].busy});
      else passes++;
    end
  endtask

  task automatic test_odd_start();
    trigger(0, 8'h02, 1);
    capture(0, -1, 8'h00, 600);
    checks++;
    if (tr.size() !== 515) begin
      $display("FAIL odd_len got %0d want 515", tr.size());
    end else begin
      passes++;
      checks++;
      if (stall_count() !== 514)
        $display("FAIL odd_stall got %0d want 514", stall_count());
      else passes++;
      checks++;
      if ({tr[1].rdy, tr[1].rw, tr[1].a} !== {2'b01, 16'hC123})
        $display("FAIL odd_align got %h want 1c123",
                 {tr[1].rdy, tr[1].rw, tr[1].a});
      else passes++;
      checks++;
      if ((tr[2].c & 1) !== 0)
        $display("FAIL odd_rd_parity got %0d want 0", tr[2].c & 1);
      else passes++;
      check_xfer("odd", 2, 16'h0200);
      checks++;
      if (done_count() !== 1)
        $display("FAIL odd_done got %0d want 1", done_count());
      else passes++;
    end
  endtask

  task automatic test_memcpy();
    logic [7:0] exp4 [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [15:0] ea;
    int bad = 0;
    trigger(1, 8'h07, 0);
    capture(1, -1, 8'h00, 40);
    checks++;
    if (tr.size() !== 10) begin
      $display("FAIL mc_len got %0d want 10", tr.size());
    end else begin
      passes++;
      checks++;
      if (stall_count() !== 9)
        $display("FAIL mc_stall got %0d want 9", stall_count());
      else passes++;
      for (int i = 0; i < 4; i++) begin
        ea = 16'h0700 + 16'(i);
        if ({tr[1+2*i].rw, tr[1+2*i].a} !== {1'b1, ea}) bad++;
        ea = 16'h0300 + 16'(i);
        if ({tr[2+2*i].rw, tr[2+2*i].a, tr[2+2*i].d}
            !== {1'b0, ea, exp4[i]}) begin
          bad++;
          $display("FAIL mc_write%0d got %h/%h want %h/%h", i,
                   tr[2+2*i].a, tr[2+2*i].d, ea, exp4[i]);
        end
      end
      checks++;
      if (bad !== 0)
        $display("FAIL mc_pairs got %0d bad want 0", bad);
      else passes++;
      checks++;
      if (tr[9].done !== 1'b1)
        $display("FAIL mc_done got %b want 1", tr[9].done);
      else passes++;
    end
    checks++;
    if (r1_busy !== 1'b0)
      $display("FAIL mc_other_busy got %b want 0", r1_busy);
    else passes++;
  endtask

  task automatic test_boundary_back_to_back();
    trigger(0, 8'hFF, 0);
    capture(0, 513, 8'h01, 600);
    checks++;
    if (tr.size() !== 515) begin
      $display("FAIL bnd_len got %0d want 515", tr.size());
    end else begin
      passes++;
      check_xfer("bnd", 1, 16'hFF00);
      checks++;
      if (tr[511].a !== 16'hFFFF)
        $display("FAIL bnd_last got %h want ffff", tr[511].a);
      else passes++;
      checks++;
      if ({tr[513].done, tr[513].rdy, tr[513].rw, tr[513].a}
          !== {3'b110, 16'h4014})
        $display("FAIL bnd_retrig got %h want 64014",
                 {tr[513].done, tr[513].rdy, tr[513].rw, tr[513].a});
      else passes++;
      checks++;
      if ({tr[514].rdy, tr[514].busy, tr[514].rw, tr[514].a}
          !== {3'b011, 16'hC123})
        $display("FAIL bnd_halt2 got %h want 3c123",
                 {tr[514].rdy, tr[514].busy, tr[514].rw, tr[514].a});
      else passes++;
    end
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    do_reset();
    trigger(0, 8'h03, 0);
    for (int n = 0; n < 200; n++) begin
      step();
      idle();
      if (n == 199) rst_n = 1'b0;
      #1;
    end
    checks++;
    if ({r1_rdy, r1_rw, r1_a} !== {2'b01, 16'h0363})
      $display("FAIL rst_100th got %h want 10363",
               {r1_rdy, r1_rw, r1_a});
    else passes++;
    step();
    rst_n = 1'b1;
    cyc = 0;
    idle();
    #1;
    checks++;
    if ({r1_rdy, r1_busy, r1_done, r1_rw, r1_a}
        !== {4'b1001, 16'hC123})
      $display("FAIL rst_idle got %h want 9c123",
               {r1_rdy, r1_busy, r1_done, r1_rw, r1_a});
    else passes++;
    for (int n = 0; n < 20; n++) begin
      step();
      idle();
      #1;
      if ((r1_rw == 1'b0 && r1_a == 16'h2004) || !r1_rdy) bad++;
    end
    checks++;
    if (bad !== 0)
      $display("FAIL rst_quiet got %0d bad want 0", bad);
    else passes++;
    trigger(0, 8'h03, 0);
    step();
    idle();
    #1;
    checks++;
    if ({r1_rdy, r1_do} !== {1'b0, 8'h00})
      $display("FAIL rst_byteclr got %h want 000", {r1_rdy, r1_do});
    else passes++;
  endtask

  initial begin
    checks = 0;
    passes = 0;
    cyc    = 0;
    for (int a = 0; a < 65536; a++)
      mem[a] = 8'(a) ^ 8'(a >> 8) ^ 8'hA5;
    mem[16'h0700] = 8'h11;
    mem[16'h0701] = 8'h22;
    mem[16'h0702] = 8'h33;
    mem[16'h0703] = 8'h44;
    rst_n = 1'b0;
    idle();
    repeat (3) step();
    rst_n = 1'b1;
    cyc = 0;
    test_reset();
    test_passthrough();
    test_even_start();
    test_odd_start();
    test_memcpy();
    test_boundary_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
